wb_regfile: RTL and testbench
=============================

# wb_regfile

Write-back register file for the 16-bit pipeline. It sits directly downstream of the MEM/WB latch and commits its write-enable, lane-select (`quarter`), destination register and write data into a 32 x 16 register array. It provides two combinational read ports to decode, and an optional write-to-read bypass. After reset, a sequencer clears the array one entry per cycle; `busy` is asserted until the clear completes.

## Interface
Parameters:
- `DATA_W`, 16, register width. Fixed at 16; lane logic assumes two 8-bit bytes.
- `ADDR_W`, 5, register address width. Array depth is 2^ADDR_W = 32.

Ports:
- `clk` in 1: single clock. All state updates on posedge.
- `rst` in 1: synchronous, active-high reset.
- `write` in 1: commit request from MEM/WB.
- `quarter` in 2: lane select for the commit.
- `writeReg` in 5: destination register.
- `writeData` in 16: commit data.
- `rd_addr_a` in 5: read port A address.
- `rd_addr_b` in 5: read port B address.
- `rd_data_a` out 16: read port A data (combinational).
- `rd_data_b` out 16: read port B data (combinational).
- `busy` out 1: clear sequence in progress.
- `wr_drop` out 1: sticky flag; a commit was discarded.

## Operation
- FSM states: CLEAR, RUN.
- Reset (`rst`=1 at posedge):
  - State goes to CLEAR.
  - Clear pointer is set to 0.
  - `busy`=1.
  - `wr_drop`=0.
  - Array contents are not touched while `rst` is held.
- CLEAR:
  - On each posedge with `rst`=0, reg[ptr] is set to 0 and ptr increments.
  - At ptr=31, the write of reg[31] occurs and the FSM goes to RUN. `busy` falls at that same edge.
  - Total: 32 cycles after `rst` deasserts.
- RUN: a posedge with `write`=1 and `writeReg`≠0 updates reg[writeReg] according to `quarter`:
  - 00: full word = `writeData[15:0]`.
  - 01: low byte = `writeData[7:0]`; high byte retained.
  - 10: high byte = `writeData[15:8]`; low byte retained.
  - 11: full word = {8'h00, `writeData[7:0]`}.
- Register 0 is hardwired to 0. Writes to it are silently ignored and do not set `wr_drop`.
- A `write`=1 in CLEAR is discarded and sets `wr_drop`=1. `wr_drop` stays set until `rst`.
- Reads:
  - `rd_data_x` = reg[`rd_addr_x`].
  - Forced to 16'h0000 while `busy`=1.
  - Forced to 16'h0000 when `rd_addr_x`=0.
- Reset mid-CLEAR restarts the sequence at ptr 0. Reset mid-RUN leaves array contents for the new clear to overwrite.

## Timing
- Commit latency: one edge. Data presented in cycle N is visible in the array after posedge N.
- Read ports are purely combinational from address and array. No read latency.
- Simultaneous read and write of the same register in the same cycle:
  - Without bypass: the read returns the old value; the new value appears after the edge.
  - With bypass: see Configuration.
- Both read ports are independent. Both may address the same register.
- `busy` and `wr_drop` are registered outputs, updated only at posedge.

## Configuration
- Macro: `WB_REGFILE_BYPASS_EN`.
- Defined:
  - If `write`=1, state is RUN, `writeReg`≠0 and `rd_addr_x`==`writeReg`, then `rd_data_x` returns the lane-merged value being committed this cycle.
  - The merge is the `quarter` rule applied to the current array contents.
  - This removes the WB->ID hazard bubble.
- Undefined: no bypass path. Reads always return array contents; decode must stall one cycle on WB->ID hazards.

## Test plan
- Reset, then hold `rst`=0:
  - `busy`=1 for exactly 32 cycles, then 0.
  - All 32 reads return 16'h0000.
  - `wr_drop`=0.
- In RUN, write reg5 = 16'hA5C3 with `quarter`=00, then `quarter`=01 with data 16'h0011:
  - Reg5 reads 16'hA511.
  - Then `quarter`=10 with 16'h7700 -> reg5 reads 16'h7711.
  - Then `quarter`=11 with 16'hFF9C -> reg5 reads 16'h009C.
- Write reg0 = 16'hFFFF -> reg0 reads 16'h0000 and `wr_drop` stays 0.
- Assert `write` (reg3 = 16'h1234) during cycle 10 of CLEAR:
  - `wr_drop`=1 from the next edge.
  - Reg3 reads 0 after the clear completes.
  - A subsequent `rst` returns `wr_drop` to 0.
- Same-cycle write of reg7 = 16'hBEEF with `rd_addr_a`=7, reg7 previously 16'h0001:
  - With `WB_REGFILE_BYPASS_EN`: `rd_data_a`=16'hBEEF in that cycle.
  - Without the macro: `rd_data_a`=16'h0001 in that cycle and 16'hBEEF next cycle.
- Assert `rst` at ptr=20 of CLEAR: `busy` stays 1, and the sequence takes a full 32 cycles after release.

Source files
------------

// File: rtl/wb_regfile.sv
// Write-back register file: 32x16 array, two async read ports,
// post-reset clear sequencer. Macro WB_REGFILE_BYPASS_EN enables WB->ID bypass.
// Ports: clk, rst (sync, active-high); write/quarter/writeReg/writeData commit
// from MEM/WB; rd_addr_a/b -> rd_data_a/b; busy (clearing), wr_drop (sticky).
module wb_regfile #(
  parameter int DATA_W = 16,
  parameter int ADDR_W = 5
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              write,
  input  logic [1:0]        quarter,
  input  logic [ADDR_W-1:0] writeReg,
  input  logic [DATA_W-1:0] writeData,
  input  logic [ADDR_W-1:0] rd_addr_a,
  input  logic [ADDR_W-1:0] rd_addr_b,
  output logic [DATA_W-1:0] rd_data_a,
  output logic [DATA_W-1:0] rd_data_b,
  output logic              busy,
  output logic              wr_drop
);

  localparam int DEPTH = 1 << ADDR_W;
  localparam int H     = DATA_W / 2;

  typedef enum logic {
    CLEAR,
    RUN
  } state_t;

  state_t            r_state;
  state_t            w_state_nxt;
  logic [ADDR_W-1:0] r_ptr;
  logic [ADDR_W-1:0] w_ptr_nxt;
  logic              r_busy;
  logic              r_drop;
  logic [DATA_W-1:0] r_mem [DEPTH];

  logic              w_wr_en;
  logic              w_drop_set;
  logic [DATA_W-1:0] w_old;
  logic [DATA_W-1:0] w_merged;

  assign w_wr_en = (r_state == RUN) && write &&
                   (writeReg != '0);

  assign w_drop_set = (r_state == CLEAR) && write &&
                      (writeReg != '0);

  assign w_old = r_mem[writeReg];

  // Lane merge of commit data into the current word
  always_comb begin
    w_merged = writeData;
    unique case (quarter)
      2'b00: w_merged = writeData;
      2'b01: w_merged = {w_old[DATA_W-1:H],
                         writeData[H-1:0]};
      2'b10: w_merged = {writeData[DATA_W-1:H],
                         w_old[H-1:0]};
      2'b11: w_merged = {{(DATA_W-H){1'b0}},
                         writeData[H-1:0]};
      default: w_merged = writeData;
    endcase
  end

  always_comb begin
    w_state_nxt = r_state;
    w_ptr_nxt   = r_ptr;
    unique case (r_state)
      CLEAR: begin
        w_ptr_nxt = r_ptr + 1'b1;
        if (r_ptr == ADDR_W'(DEPTH - 1))
          w_state_nxt = RUN;
      end
      RUN: w_state_nxt = RUN;
      default: w_state_nxt = CLEAR;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= CLEAR;
      r_ptr   <= '0;
      r_busy  <= 1'b1;
      r_drop  <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_ptr   <= w_ptr_nxt;
      r_busy  <= (w_state_nxt == CLEAR);
      if (w_drop_set)
        r_drop <= 1'b1;
    end
  end

  // Array holds its contents through reset; the clear rewrites it
  always_ff @(posedge clk) begin
    if (!rst) begin
      if (r_state == CLEAR)
        r_mem[r_ptr] <= '0;
      else if (w_wr_en)
        r_mem[writeReg] <= w_merged;
    end
  end

  function automatic logic [DATA_W-1:0] rd_port(
    input logic [ADDR_W-1:0] a
  );
    logic [DATA_W-1:0] v;
    v = r_mem[a];
`ifdef WB_REGFILE_BYPASS_EN
    if (w_wr_en && (a == writeReg))
      v = w_merged;
`endif
    if (r_busy || (a == '0))
      v = '0;
    return v;
  endfunction

  assign rd_data_a = rd_port(rd_addr_a);
  assign rd_data_b = rd_port(rd_addr_b);
  assign busy      = r_busy;
  assign wr_drop   = r_drop;

endmodule

// File: tb/tb_wb_regfile.sv
// Self-checking bench for wb_regfile: vector table, random vs model,
// hand sequences for clear, dropped commits and mid-clear reset.
module tb_wb_regfile;

  logic        clk = 1'b0;
  logic        rst;
  logic        write;
  logic [1:0]  quarter;
  logic [4:0]  writeReg;
  logic [15:0] writeData;
  logic [4:0]  rd_addr_a;
  logic [4:0]  rd_addr_b;
  logic [15:0] rd_data_a;
  logic [15:0] rd_data_b;
  logic        busy;
  logic        wr_drop;

  int n_chk  = 0;
  int n_fail = 0;

  logic [15:0] m [32];

  always #5 clk = ~clk;

  wb_regfile dut (
    .clk       (clk),
    .rst       (rst),
    .write     (write),
    .quarter   (quarter),
    .writeReg  (writeReg),
    .writeData (writeData),
    .rd_addr_a (rd_addr_a),
    .rd_addr_b (rd_addr_b),
    .rd_data_a (rd_data_a),
    .rd_data_b (rd_data_b),
    .busy      (busy),
    .wr_drop   (wr_drop)
  );

  typedef struct packed {
    logic        w;
    logic [1:0]  q;
    logic [4:0]  r;
    logic [15:0] d;
    logic [4:0]  a;
    logic [4:0]  b;
    logic [15:0] ea;
    logic [15:0] eb;
  } vec_t;

  vec_t tbl [13];

  task automatic chk(input string nm,
                     input logic [15:0] act,
                     input logic [15:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h",
               nm, act, exp);
    end
  endtask

  function automatic logic [15:0] mrg(
    input logic [15:0] o, input logic [1:0] q,
    input logic [15:0] d);
    case (q)
      2'd0: return d;
      2'd1: return (o & 16'hFF00) | (d & 16'h00FF);
      2'd2: return (o & 16'h00FF) | (d & 16'hFF00);
      default: return d % 256;
    endcase
  endfunction

  function automatic logic [15:0] mread(
    input logic [4:0] a);
    if (a == 0) return 16'h0;
`ifdef WB_REGFILE_BYPASS_EN
    if (write && writeReg == a)
      return mrg(m[a], quarter, writeData);
`endif
    return m[a];
  endfunction

  task automatic drive(input logic w,
    input logic [1:0] q, input logic [4:0] r,
    input logic [15:0] d, input logic [4:0] a,
    input logic [4:0] b);
    write = w; quarter = q; writeReg = r;
    writeData = d; rd_addr_a = a; rd_addr_b = b;
    #1;
  endtask

  // Edge in RUN: model commits what the DUT sees
  task automatic commit();
    logic w; logic [1:0] q;
    logic [4:0] r; logic [15:0] d;
    w = write; q = quarter;
    r = writeReg; d = writeData;
    @(posedge clk); #1;
    if (w && r != 0) m[r] = mrg(m[r], q, d);
    write = 1'b0;
  endtask

  task automatic wait_clear(output int n);
    n = 0;
    do begin
      @(posedge clk); #1;
      n++;
    end while (busy && n < 64);
    foreach (m[i]) m[i] = 16'h0;
  endtask

  task automatic do_rst();
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: timeout");
    $fatal(1, "timeout");
  end

  initial begin
    int n;
    logic [4:0] ra;
    logic [4:0] rb;
    rst = 1'b1;
    drive(0, 0, 0, 0, 5, 9);
    @(posedge clk); #1;
    @(posedge clk); #1;
    chk("rst_busy", {15'h0, busy}, 16'h1);
    chk("rst_drop", {15'h0, wr_drop}, 16'h0);
    chk("rst_rda", rd_data_a, 16'h0);
    chk("rst_rdb", rd_data_b, 16'h0);
    rst = 1'b0;
    wait_clear(n);
    chk("clear_len", 16'(n), 16'd32);
    chk("clear_drop", {15'h0, wr_drop}, 16'h0);
    for (int i = 0; i < 32; i++) begin
      drive(0, 0, 0, 0, 5'(i), 5'(31 - i));
      chk("clear_rda", rd_data_a, 16'h0);
      chk("clear_rdb", rd_data_b, 16'h0);
    end

    tbl[0]  = '{1, 0, 5, 16'hA5C3, 6, 0,
                16'h0, 16'h0};
    tbl[1]  = '{0, 0, 0, 16'h0, 5, 5,
                16'hA5C3, 16'hA5C3};
    tbl[2]  = '{1, 1, 5, 16'h0011, 0, 6,
                16'h0, 16'h0};
    tbl[3]  = '{0, 0, 0, 16'h0, 5, 0,
                16'hA511, 16'h0};
    tbl[4]  = '{1, 2, 5, 16'h7700, 6, 6,
                16'h0, 16'h0};
    tbl[5]  = '{0, 0, 0, 16'h0, 5, 5,
                16'h7711, 16'h7711};
    tbl[6]  = '{1, 3, 5, 16'hFF9C, 0, 0,
                16'h0, 16'h0};
    tbl[7]  = '{0, 0, 0, 16'h0, 5, 6,
                16'h009C, 16'h0};
    tbl[8]  = '{1, 0, 0, 16'hFFFF, 5, 0,
                16'h009C, 16'h0};
    tbl[9]  = '{0, 0, 0, 16'h0, 0, 5,
                16'h0, 16'h009C};
    tbl[10] = '{1, 0, 7, 16'h0001, 5, 6,
                16'h009C, 16'h0};
`ifdef WB_REGFILE_BYPASS_EN
    tbl[11] = '{1, 0, 7, 16'hBEEF, 7, 7,
                16'hBEEF, 16'hBEEF};
`else
    tbl[11] = '{1, 0, 7, 16'hBEEF, 7, 7,
                16'h0001, 16'h0001};
`endif
    tbl[12] = '{0, 0, 0, 16'h0, 7, 7,
                16'hBEEF, 16'hBEEF};

    for (int i = 0; i < 13; i++) begin
      drive(tbl[i].w, tbl[i].q, tbl[i].r,
            tbl[i].d, tbl[i].a, tbl[i].b);
      chk($sformatf("tbl%0d_a", i),
          rd_data_a, tbl[i].ea);
      chk($sformatf("tbl%0d_b", i),
          rd_data_b, tbl[i].eb);
      commit();
    end
    chk("tbl_drop", {15'h0, wr_drop}, 16'h0);

    for (int i = 0; i < 400; i++) begin
      ra = 5'($urandom);
      rb = 5'($urandom);
      n  = int'($urandom_range(0, 3));
      drive(1'($urandom), 2'($urandom),
            (n == 0) ? ra : 5'($urandom),
            16'($urandom), ra, rb);
      chk("rnd_a", rd_data_a, mread(ra));
      chk("rnd_b", rd_data_b, mread(rb));
      commit();
    end
    chk("rnd_busy", {15'h0, busy}, 16'h0);
    chk("rnd_drop", {15'h0, wr_drop}, 16'h0);

    do_rst();
    repeat (9) begin
      @(posedge clk); #1;
    end
    drive(1, 0, 3, 16'h1234, 3, 3);
    chk("drop_pre", {15'h0, wr_drop}, 16'h0);
    @(posedge clk); #1;
    write = 1'b0;
    chk("drop_set", {15'h0, wr_drop}, 16'h1);
    wait_clear(n);
    chk("drop_busy", {15'h0, busy}, 16'h0);
    drive(0, 0, 0, 0, 3, 3);
    chk("drop_r3", rd_data_a, 16'h0);
    chk("drop_hold", {15'h0, wr_drop}, 16'h1);
    rst = 1'b1;
    @(posedge clk); #1;
    chk("drop_clr", {15'h0, wr_drop}, 16'h0);
    rst = 1'b0;
    wait_clear(n);
    chk("clear2_len", 16'(n), 16'd32);

    do_rst();
    repeat (20) begin
      @(posedge clk); #1;
    end
    chk("mid_busy0", {15'h0, busy}, 16'h1);
    rst = 1'b1;
    @(posedge clk); #1;
    chk("mid_busy1", {15'h0, busy}, 16'h1);
    rst = 1'b0;
    wait_clear(n);
    chk("mid_len", 16'(n), 16'd32);
    drive(0, 0, 0, 0, 5, 7);
    chk("mid_r5", rd_data_a, 16'h0);
    chk("mid_r7", rd_data_b, 16'h0);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
